// File: rtl/bldc_pkg.sv
// Shared constants for the six-step BLDC commutator: state encodings, commutation
// table, gate bit positions and the step-advance helper.
package bldc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    DRIVE = 2'd2
  } bldc_state_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DEAD  = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  localparam logic [2:0] STEP_COUNT = 3'd6;
  localparam logic [2:0] LAST_STEP  = STEP_COUNT - 3'd1;

  localparam int GATE_AH = 5;
  localparam int GATE_AL = 4;
  localparam int GATE_BH = 3;
  localparam int GATE_BL = 2;
  localparam int GATE_CH = 1;
  localparam int GATE_CL = 0;

  localparam logic [5:0] TBL_S0 = 6'b100100;
  localparam logic [5:0] TBL_S1 = 6'b000110;
  localparam logic [5:0] TBL_S2 = 6'b010010;
  localparam logic [5:0] TBL_S3 = 6'b011000;
  localparam logic [5:0] TBL_S4 = 6'b001001;
  localparam logic [5:0] TBL_S5 = 6'b100001;

  // Next step index with wrap in both directions (dir=1 walks backwards).
  function automatic logic [2:0] step_next(input logic [2:0] idx, input logic dir);
    logic [2:0] res;
    if (dir) begin
      res = (idx == 3'd0) ? LAST_STEP : idx - 3'd1;
    end else begin
      res = (idx >= LAST_STEP) ? 3'd0 : idx + 3'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bldc_commutator_ctrl_pwm.sv
// High-side PWM for the commutator: free-running counter while active, compared
// against duty. Only instantiated when BLDC_PWM_EN is defined.
module bldc_pwm
  import bldc_pkg::*;
#(
  parameter int DUTY_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm_on
);

  logic [DUTY_W-1:0] pwm_cnt;

  // Counter wraps naturally at 2^DUTY_W; held at zero while the sequencer idles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= {DUTY_W{1'b0}};
    end else if (en) begin
      pwm_cnt <= pwm_cnt + {{(DUTY_W-1){1'b0}}, 1'b1};
    end else begin
      pwm_cnt <= {DUTY_W{1'b0}};
    end
  end

  assign pwm_on = (pwm_cnt < duty);

endmodule

// File: rtl/bldc_commutator_ctrl.sv
// Six-step BLDC commutation sequencer with break-before-make dead time.
// Optional high-side PWM is enabled with macro BLDC_PWM_EN.
module bldc_commutator_ctrl
  import bldc_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int DEADTIME = 4,
  parameter int DUTY_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                dir,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DUTY_W-1:0]   duty,
  output logic [5:0]          gate,
  output logic [2:0]          step_idx,
  output logic                step_tick,
  output logic                busy
);

  localparam logic [PERIOD_W-1:0] DT_LAST = PERIOD_W'(DEADTIME - 1);
  localparam logic [PERIOD_W-1:0] P_MIN   = PERIOD_W'(DEADTIME + 1);
  localparam logic [PERIOD_W-1:0] ONE     = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] ZERO    = {PERIOD_W{1'b0}};

  logic [1:0]          state, state_nxt;
  logic [PERIOD_W-1:0] cnt, cnt_nxt;
  logic [PERIOD_W-1:0] p_lat, p_nxt, p_clamped;
  logic [2:0]          idx_nxt;
  logic                tick_nxt;
  logic [5:0]          tbl_val, hs_mask, gate_nxt;
  logic                pwm_on;

`ifdef BLDC_PWM_EN
  bldc_pwm #(
    .DUTY_W(DUTY_W)
  ) u_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state != ST_IDLE),
    .duty   (duty),
    .pwm_on (pwm_on)
  );
`else
  logic unused_duty;
  assign unused_duty = ^duty;
  assign pwm_on      = 1'b1;
`endif

  assign p_clamped = (period < P_MIN) ? P_MIN : period;

  // Commutation table lookup for the current step.
  always_comb begin
    tbl_val = 6'b000000;
    case (step_idx)
      3'd0:    tbl_val = TBL_S0;
      3'd1:    tbl_val = TBL_S1;
      3'd2:    tbl_val = TBL_S2;
      3'd3:    tbl_val = TBL_S3;
      3'd4:    tbl_val = TBL_S4;
      3'd5:    tbl_val = TBL_S5;
      default: tbl_val = 6'b000000;
    endcase
  end

  // Sequencer next-state: stop has priority over the step boundary.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    p_nxt     = p_lat;
    idx_nxt   = step_idx;
    tick_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = ZERO;
        if (run) begin
          state_nxt = ST_DEAD;
          p_nxt     = p_clamped;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DEAD: begin
        if (!run) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = ZERO;
        end else if (cnt == DT_LAST) begin
          state_nxt = ST_DRIVE;
          cnt_nxt   = cnt + ONE;
        end else begin
          cnt_nxt   = cnt + ONE;
        end
      end
      ST_DRIVE: begin
        if (!run) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = ZERO;
        end else if (cnt == p_lat - ONE) begin
          state_nxt = ST_DEAD;
          cnt_nxt   = ZERO;
          p_nxt     = p_clamped;
          idx_nxt   = step_next(step_idx, dir);
          tick_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = ZERO;
      end
    endcase
  end

  // Gate image for the next cycle; high sides are gated by the PWM compare.
  always_comb begin
    hs_mask          = 6'b111111;
    hs_mask[GATE_AH] = pwm_on;
    hs_mask[GATE_BH] = pwm_on;
    hs_mask[GATE_CH] = pwm_on;
    if (state_nxt == ST_DRIVE) begin
      gate_nxt = tbl_val & hs_mask;
    end else begin
      gate_nxt = 6'b000000;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= ZERO;
      p_lat     <= P_MIN;
      step_idx  <= 3'd0;
      step_tick <= 1'b0;
      busy      <= 1'b0;
      gate      <= 6'b000000;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      p_lat     <= p_nxt;
      step_idx  <= idx_nxt;
      step_tick <= tick_nxt;
      busy      <= (state_nxt != ST_IDLE);
      gate      <= gate_nxt;
    end
  end

endmodule

// File: tb/tb_bldc_commutator_ctrl.sv
// Directed self-checking bench for bldc_commutator_ctrl (DEADTIME=4).
// Extra PWM checks are compiled in when BLDC_PWM_EN is defined.
module tb_bldc_commutator_ctrl;

  localparam int DT = 4;

`ifdef BLDC_PWM_EN
  localparam logic [5:0] CMP_MASK = 6'b010101;
`else
  localparam logic [5:0] CMP_MASK = 6'b111111;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        dir;
  logic [15:0] period;
  logic [7:0]  duty;
  logic [5:0]  gate;
  logic [2:0]  step_idx;
  logic        step_tick;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  bldc_commutator_ctrl #(
    .PERIOD_W(16),
    .DEADTIME(DT),
    .DUTY_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .dir       (dir),
    .period    (period),
    .duty      (duty),
    .gate      (gate),
    .step_idx  (step_idx),
    .step_tick (step_tick),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at cycle 1 of a step and checks all p cycles, leaving us at cycle 1 of the next.
  task automatic check_step(input logic [2:0] idx, input logic [5:0] tbl, input int p,
                            input logic first_tick, input logic stop_end);
    logic [5:0] exp_g;
    for (int c = 1; c <= p; c++) begin
      exp_g = (c <= DT) ? 6'b000000 : tbl;
      chk("step_idx", 32'(step_idx), 32'(idx));
      chk("step_tick", 32'(step_tick), (c == 1) ? 32'(first_tick) : 32'd0);
      chk("busy", 32'(busy), 32'd1);
      chk("gate", 32'(gate & CMP_MASK), 32'(exp_g & CMP_MASK));
      chk("gate_in_table", 32'(gate & ~exp_g), 32'd0);
      chk("phase_excl", 32'((gate[5] & gate[4]) | (gate[3] & gate[2]) | (gate[1] & gate[0])), 32'd0);
      if (c == p && stop_end) run = 1'b0;
      tick();
    end
  endtask

`ifdef BLDC_PWM_EN
  task automatic pwm_window(input logic [7:0] d, input int exp_ah, input string tag);
    int ah_cnt;
    int bl_cnt;
    ah_cnt = 0;
    bl_cnt = 0;
    duty   = d;
    period = 16'd600;
    run    = 1'b1;
    tick();
    repeat (DT) tick();
    for (int c = 0; c < 512; c++) begin
      ah_cnt += int'(gate[5]);
      bl_cnt += int'(gate[2]);
      tick();
    end
    chk({tag, "_ah"}, 32'(ah_cnt), 32'(exp_ah));
    chk({tag, "_bl"}, 32'(bl_cnt), 32'd512);
    run = 1'b0;
    tick();
    chk({tag, "_stop"}, 32'(busy), 32'd0);
  endtask
`endif

  initial begin
    rst_n  = 1'b0;
    run    = 1'b0;
    dir    = 1'b0;
    period = 16'd10;
    duty   = 8'd0;
    repeat (2) tick();
    chk("rst_gate", 32'(gate), 32'd0);
    chk("rst_idx", 32'(step_idx), 32'd0);
    chk("rst_tick", 32'(step_tick), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_gate", 32'(gate), 32'd0);

    // Start and one full forward revolution at period 10.
    run = 1'b1;
    tick();
    check_step(3'd0, 6'b100100, 10, 1'b0, 1'b0);
    check_step(3'd1, 6'b000110, 10, 1'b1, 1'b0);
    check_step(3'd2, 6'b010010, 10, 1'b1, 1'b0);
    check_step(3'd3, 6'b011000, 10, 1'b1, 1'b0);
    check_step(3'd4, 6'b001001, 10, 1'b1, 1'b0);
    check_step(3'd5, 6'b100001, 10, 1'b1, 1'b0);

    // Reverse from step 0 wraps to 5; dir set mid-step acts at the next boundary.
    dir = 1'b1;
    check_step(3'd0, 6'b100100, 10, 1'b1, 1'b0);
    check_step(3'd5, 6'b100001, 10, 1'b1, 1'b0);
    dir = 1'b0;
    check_step(3'd4, 6'b001001, 10, 1'b1, 1'b0);

    // Clamp: period 0 and 3 both give 4 dead + 1 drive.
    period = 16'd0;
    check_step(3'd5, 6'b100001, 10, 1'b1, 1'b0);
    period = 16'd3;
    check_step(3'd0, 6'b100100, 5, 1'b1, 1'b0);
    period = 16'd10;
    check_step(3'd1, 6'b000110, 5, 1'b1, 1'b0);
    check_step(3'd2, 6'b010010, 10, 1'b1, 1'b0);
    check_step(3'd3, 6'b011000, 10, 1'b1, 1'b0);
    check_step(3'd4, 6'b001001, 10, 1'b1, 1'b0);
    check_step(3'd5, 6'b100001, 10, 1'b1, 1'b0);
    check_step(3'd0, 6'b100100, 10, 1'b1, 1'b0);
    check_step(3'd1, 6'b000110, 10, 1'b1, 1'b0);

    // Stop mid-DRIVE at step 2.
    repeat (6) tick();
    chk("pre_stop_gate", 32'(gate & CMP_MASK), 32'(6'b010010 & CMP_MASK));
    run = 1'b0;
    tick();
    chk("stop_gate", 32'(gate), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_idx", 32'(step_idx), 32'd2);
    chk("stop_tick", 32'(step_tick), 32'd0);
    repeat (3) tick();
    chk("stopped_busy", 32'(busy), 32'd0);
    chk("stopped_idx", 32'(step_idx), 32'd2);

    // Restart, then stop exactly on the boundary cycle.
    run = 1'b1;
    tick();
    check_step(3'd2, 6'b010010, 10, 1'b0, 1'b1);
    chk("bstop_tick", 32'(step_tick), 32'd0);
    chk("bstop_idx", 32'(step_idx), 32'd2);
    chk("bstop_busy", 32'(busy), 32'd0);
    chk("bstop_gate", 32'(gate), 32'd0);

    // Restart begins with a full dead phase.
    run = 1'b1;
    tick();
    check_step(3'd2, 6'b010010, 10, 1'b0, 1'b0);

    // Asynchronous reset mid-DRIVE of step 3.
    repeat (6) tick();
    chk("pre_rst_gate", 32'(gate & CMP_MASK), 32'(6'b011000 & CMP_MASK));
    rst_n = 1'b0;
    #1;
    chk("arst_gate", 32'(gate), 32'd0);
    chk("arst_idx", 32'(step_idx), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_tick", 32'(step_tick), 32'd0);
    run = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

`ifdef BLDC_PWM_EN
    pwm_window(8'd64, 128, "pwm64");
    pwm_window(8'd0, 0, "pwm0");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
